uart_wb_master: RTL

UART_WB_MASTER -- requirements
Module: uart_wb_master

---
 rtl/uart_wb_master.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_wb_master.sv
// UART-to-Wishbone bridge master.
// Commands arrive as bytes: CMD_WR + 4 address bytes + 4 data bytes, or
// CMD_RD + 4 address bytes (all MSB first). One Wishbone classic/pipelined
// single transfer is issued, then a status byte ('K' or 'E') is returned,
// followed by four read-data bytes for a successful read.
module uart_wb_master #(
   parameter int unsigned ACK_TIMEOUT = 255,
   parameter logic [7:0]  CMD_WR      = 8'h57,
   parameter logic [7:0]  CMD_RD      = 8'h52
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [7:0]  rx_data_i,
   input  logic        rx_vld_i,
   input  logic        rx_err_i,
   output logic [7:0]  tx_data_o,
   output logic        tx_vld_o,
   input  logic        tx_rdy_i,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_data_m_o,
   output logic [3:0]  wb_sel_o,
   input  logic [31:0] wb_data_s_i,
   input  logic        wb_ack_i,
   input  logic        wb_err_i,
   input  logic        wb_stall_i,
   output logic        drop_o
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ADDR      = 3'd1,
      WDATA     = 3'd2,
      BUS_REQ   = 3'd3,
      BUS_WAIT  = 3'd4,
      RESP_STAT = 3'd5,
      RESP_DATA = 3'd6
   } state_t;

   localparam logic [8:0] TMO_LIM  = 9'(ACK_TIMEOUT);
   localparam logic [7:0] RESP_OK  = 8'h4B;
   localparam logic [7:0] RESP_ERR = 8'h45;

   // Byte idx 0 is the most significant byte of the word.
   function automatic logic [7:0] msb_byte(input logic [31:0] word, input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = word[31:24];
         2'd1:    b = word[23:16];
         2'd2:    b = word[15:8];
         2'd3:    b = word[7:0];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   state_t      r_state, w_state_nxt;
   logic        r_is_wr, w_is_wr_nxt;
   logic        r_fail,  w_fail_nxt;
   logic [1:0]  r_cnt,   w_cnt_nxt;
   logic [7:0]  r_tmo,   w_tmo_nxt;
   logic [31:0] r_adr,   w_adr_nxt;
   logic [31:0] r_wdat,  w_wdat_nxt;
   logic [31:0] r_rdat,  w_rdat_nxt;
   logic        r_drop,  w_drop_nxt;
   logic        r_cyc,   w_cyc_nxt;
   logic        r_stb,   w_stb_nxt;
   logic        r_we,    w_we_nxt;
   logic [3:0]  r_sel,   w_sel_nxt;
   logic        r_tx_vld, w_tx_vld_nxt;
   logic [7:0]  r_tx_data, w_tx_data_nxt;
   logic        w_resp;

   assign w_resp = wb_ack_i | wb_err_i;

   // Next-state, datapath and next-output computation.
   always_comb begin
      w_state_nxt = r_state;
      w_is_wr_nxt = r_is_wr;
      w_fail_nxt  = r_fail;
      w_cnt_nxt   = r_cnt;
      w_tmo_nxt   = r_tmo;
      w_adr_nxt   = r_adr;
      w_wdat_nxt  = r_wdat;
      w_rdat_nxt  = r_rdat;
      w_drop_nxt  = 1'b0;

      case (r_state)
         IDLE: begin
            if (rx_vld_i && !rx_err_i && (rx_data_i == CMD_WR || rx_data_i == CMD_RD)) begin
               w_is_wr_nxt = (rx_data_i == CMD_WR);
               w_cnt_nxt   = 2'd0;
               w_adr_nxt   = 32'h0000_0000;
               w_wdat_nxt  = 32'h0000_0000;
               w_state_nxt = ADDR;
            end else if (rx_vld_i) begin
               w_drop_nxt = 1'b1;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         ADDR: begin
            if (rx_vld_i && rx_err_i) begin
               w_drop_nxt  = 1'b1;
               w_adr_nxt   = 32'h0000_0000;
               w_cnt_nxt   = 2'd0;
               w_state_nxt = IDLE;
            end else if (rx_vld_i) begin
               w_adr_nxt = {r_adr[23:0], rx_data_i};
               if (r_cnt == 2'd3) begin
                  w_cnt_nxt   = 2'd0;
                  w_state_nxt = r_is_wr ? WDATA : BUS_REQ;
               end else begin
                  w_cnt_nxt = r_cnt + 2'd1;
               end
            end else begin
               w_state_nxt = ADDR;
            end
         end
         WDATA: begin
            if (rx_vld_i && rx_err_i) begin
               w_drop_nxt  = 1'b1;
               w_adr_nxt   = 32'h0000_0000;
               w_wdat_nxt  = 32'h0000_0000;
               w_cnt_nxt   = 2'd0;
               w_state_nxt = IDLE;
            end else if (rx_vld_i) begin
               w_wdat_nxt = {r_wdat[23:0], rx_data_i};
               if (r_cnt == 2'd3) begin
                  w_cnt_nxt   = 2'd0;
                  w_state_nxt = BUS_REQ;
               end else begin
                  w_cnt_nxt = r_cnt + 2'd1;
               end
            end else begin
               w_state_nxt = WDATA;
            end
         end
         BUS_REQ: begin
            w_drop_nxt = rx_vld_i;
            // First non-stalled cycle is the accept; a response here is honoured.
            if (!wb_stall_i) begin
               if (w_resp) begin
                  w_fail_nxt  = wb_err_i;
                  w_state_nxt = RESP_STAT;
                  if (wb_ack_i && !wb_err_i && !r_is_wr) begin
                     w_rdat_nxt = wb_data_s_i;
                  end else begin
                     w_rdat_nxt = r_rdat;
                  end
               end else if (TMO_LIM <= 9'd1) begin
                  w_fail_nxt  = 1'b1;
                  w_state_nxt = RESP_STAT;
               end else begin
                  w_fail_nxt  = 1'b0;
                  w_tmo_nxt   = 8'd1;
                  w_state_nxt = BUS_WAIT;
               end
            end else begin
               w_state_nxt = BUS_REQ;
            end
         end
         BUS_WAIT: begin
            w_drop_nxt = rx_vld_i;
            if (w_resp) begin
               w_fail_nxt  = wb_err_i;
               w_tmo_nxt   = 8'd0;
               w_state_nxt = RESP_STAT;
               if (wb_ack_i && !wb_err_i && !r_is_wr) begin
                  w_rdat_nxt = wb_data_s_i;
               end else begin
                  w_rdat_nxt = r_rdat;
               end
            end else if (({1'b0, r_tmo} + 9'd1) >= TMO_LIM) begin
               // r_tmo counts response-less cycles since the accept cycle.
               w_fail_nxt  = 1'b1;
               w_tmo_nxt   = 8'd0;
               w_state_nxt = RESP_STAT;
            end else begin
               w_tmo_nxt = r_tmo + 8'd1;
            end
         end
         RESP_STAT: begin
            w_drop_nxt = rx_vld_i;
            if (tx_rdy_i) begin
               w_cnt_nxt   = 2'd0;
               w_state_nxt = (!r_fail && !r_is_wr) ? RESP_DATA : IDLE;
            end else begin
               w_state_nxt = RESP_STAT;
            end
         end
         RESP_DATA: begin
            w_drop_nxt = rx_vld_i;
            if (tx_rdy_i && r_cnt == 2'd3) begin
               w_cnt_nxt   = 2'd0;
               w_state_nxt = IDLE;
            end else if (tx_rdy_i) begin
               w_cnt_nxt = r_cnt + 2'd1;
            end else begin
               w_state_nxt = RESP_DATA;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = 2'd0;
         end
      endcase

      // Bus and transmit outputs are decoded from the next state so they are registered.
      w_cyc_nxt    = (w_state_nxt == BUS_REQ) || (w_state_nxt == BUS_WAIT);
      w_stb_nxt    = (w_state_nxt == BUS_REQ);
      w_we_nxt     = w_cyc_nxt & w_is_wr_nxt;
      w_sel_nxt    = w_cyc_nxt ? 4'hF : 4'h0;
      w_tx_vld_nxt = (w_state_nxt == RESP_STAT) || (w_state_nxt == RESP_DATA);
      case (w_state_nxt)
         RESP_STAT: w_tx_data_nxt = w_fail_nxt ? RESP_ERR : RESP_OK;
         RESP_DATA: w_tx_data_nxt = msb_byte(w_rdat_nxt, w_cnt_nxt);
         default:   w_tx_data_nxt = 8'h00;
      endcase
   end

   // State and all registered outputs, cleared asynchronously by reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state   <= IDLE;
         r_is_wr   <= 1'b0;
         r_fail    <= 1'b0;
         r_cnt     <= 2'd0;
         r_tmo     <= 8'd0;
         r_adr     <= 32'h0000_0000;
         r_wdat    <= 32'h0000_0000;
         r_rdat    <= 32'h0000_0000;
         r_drop    <= 1'b0;
         r_cyc     <= 1'b0;
         r_stb     <= 1'b0;
         r_we      <= 1'b0;
         r_sel     <= 4'h0;
         r_tx_vld  <= 1'b0;
         r_tx_data <= 8'h00;
      end else begin
         r_state   <= w_state_nxt;
         r_is_wr   <= w_is_wr_nxt;
         r_fail    <= w_fail_nxt;
         r_cnt     <= w_cnt_nxt;
         r_tmo     <= w_tmo_nxt;
         r_adr     <= w_adr_nxt;
         r_wdat    <= w_wdat_nxt;
         r_rdat    <= w_rdat_nxt;
         r_drop    <= w_drop_nxt;
         r_cyc     <= w_cyc_nxt;
         r_stb     <= w_stb_nxt;
         r_we      <= w_we_nxt;
         r_sel     <= w_sel_nxt;
         r_tx_vld  <= w_tx_vld_nxt;
         r_tx_data <= w_tx_data_nxt;
      end
   end

   assign tx_data_o   = r_tx_data;
   assign tx_vld_o    = r_tx_vld;
   assign wb_cyc_o    = r_cyc;
   assign wb_stb_o    = r_stb;
   assign wb_we_o     = r_we;
   assign wb_adr_o    = r_adr;
   assign wb_data_m_o = r_wdat;
   assign wb_sel_o    = r_sel;
   assign drop_o      = r_drop;

endmodule
